dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that services the datapath's memory-stage load/store port and produces the `dhit` stall signal. Every pipeline register advances only while `dhit` is 1. The cache sits between the memory stage (`ALUOutM`/`WriteDataM`/`ReadData`) and a 128-bit line-wide main-memory port. Misses are handled by a three-state FSM.

---
 rtl/dcache.sv | 196 +++++++++++++++++++
 tb/tb_dcache.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
// Four 16-byte lines; tag = addr[31:6], index = addr[5:4], word = addr[3:2].
// Misses go through IDLE -> (WRITEBACK ->) REFILL -> IDLE; the stalled access
// then replays in IDLE and hits.
// Optional feature macro: DCACHE_PERF_EN adds hit_count / miss_count outputs.
module dcache (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_en,
    input  logic         wr_en,
    input  logic         byte_en,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         dhit,
    output logic         mem_req,
    output logic         mem_we,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic [3:0]   r_valid;
    logic [3:0]   r_dirty;
    logic [25:0]  r_tag  [0:3];
    logic [127:0] r_data [0:3];

    logic [1:0]   w_index;
    logic [1:0]   w_word;
    logic [25:0]  w_tag;
    logic         w_access;
    logic         w_hit;

    // Word 0 of a line lives in the most significant 32 bits.
    function automatic logic [31:0] f_get_word(input logic [127:0] line,
                                               input logic [1:0]   word);
        logic [31:0] result;
        case (word)
            2'd0:    result = line[127:96];
            2'd1:    result = line[95:64];
            2'd2:    result = line[63:32];
            2'd3:    result = line[31:0];
            default: result = line[31:0];
        endcase
        return result;
    endfunction

    // Merge a word or big-endian byte store into a line (lane 0 = bits 31:24).
    function automatic logic [127:0] f_merge(input logic [127:0] line,
                                             input logic [1:0]   word,
                                             input logic         is_byte,
                                             input logic [1:0]   lane,
                                             input logic [31:0]  data);
        logic [31:0]  old_word;
        logic [31:0]  new_word;
        logic [127:0] result;
        old_word = f_get_word(line, word);
        if (is_byte) begin
            case (lane)
                2'd0:    new_word = {data[7:0], old_word[23:0]};
                2'd1:    new_word = {old_word[31:24], data[7:0], old_word[15:0]};
                2'd2:    new_word = {old_word[31:16], data[7:0], old_word[7:0]};
                2'd3:    new_word = {old_word[31:8], data[7:0]};
                default: new_word = old_word;
            endcase
        end else begin
            new_word = data;
        end
        result = line;
        case (word)
            2'd0:    result[127:96] = new_word;
            2'd1:    result[95:64]  = new_word;
            2'd2:    result[63:32]  = new_word;
            2'd3:    result[31:0]   = new_word;
            default: result         = line;
        endcase
        return result;
    endfunction

    assign w_index  = addr[5:4];
    assign w_word   = addr[3:2];
    assign w_tag    = addr[31:6];
    assign w_access = rd_en | wr_en;
    assign w_hit    = w_access & r_valid[w_index] & (r_tag[w_index] == w_tag);

    // Load data is the addressed word of the indexed line, hit or not.
    assign rdata = f_get_word(r_data[w_index], w_word);

    // State register plus line storage: store-hit merge in IDLE, refill install.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 4'b0000;
            r_dirty <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && w_hit && wr_en) begin
                r_data[w_index]  <= f_merge(r_data[w_index], w_word, byte_en,
                                            addr[1:0], wdata);
                r_dirty[w_index] <= 1'b1;
            end else if ((r_state == S_REFILL) && mem_ready) begin
                r_data[w_index]  <= mem_rdata;
                r_tag[w_index]   <= w_tag;
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end
        end
    end

    // Next-state logic and the stall / memory-port outputs.
    always_comb begin
        w_next_state = r_state;
        dhit         = 1'b1;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr[31:4];
        mem_wdata    = r_data[w_index];
        case (r_state)
            S_IDLE: begin
                dhit = ~w_access | w_hit;
                if (w_access && !w_hit) begin
                    if (r_valid[w_index] && r_dirty[w_index]) begin
                        w_next_state = S_WRITEBACK;
                    end else begin
                        w_next_state = S_REFILL;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                dhit     = 1'b0;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {r_tag[w_index], w_index};
                if (mem_ready) begin
                    w_next_state = S_REFILL;
                end else begin
                    w_next_state = S_WRITEBACK;
                end
            end
            S_REFILL: begin
                dhit    = 1'b0;
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_REFILL;
                end
            end
            default: begin
                dhit         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hit counter counts IDLE hit cycles; miss counter counts IDLE-to-miss transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) && w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if ((r_state == S_IDLE) && w_access && !w_hit) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: a line-wide memory model with programmable
// latency, a queue of expected load data, and a log of memory handshakes.
`timescale 1ns/1ps
module tb_dcache;

    logic         clk;
    logic         reset;
    logic         rd_en;
    logic         wr_en;
    logic         byte_en;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         dhit;
    logic         mem_req;
    logic         mem_we;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
`ifdef DCACHE_PERF_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;
    int mem_cnt  = 0;

    logic [127:0] mem [logic [27:0]];
    logic [31:0]  q_exp [$];
    logic         log_we [$];
    logic [27:0]  log_addr [$];
    logic [127:0] log_wdata [$];
    logic [127:0] last_wdata;

    dcache dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .byte_en   (byte_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .dhit      (dhit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef DCACHE_PERF_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rd_line(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        else return {4{4'h0, a}};
    endfunction

    // Memory model: answers a request after mem_lat waiting cycles, drops on reset.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 128'd0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_ready = 1'b0;
                mem_cnt   = 0;
            end else begin
                mem_ready = 1'b0;
                if (mem_req) begin
                    if (mem_cnt == mem_lat) begin
                        if (mem_we) mem[mem_addr] = mem_wdata;
                        else        mem_rdata = rd_line(mem_addr);
                        log_we.push_back(mem_we);
                        log_addr.push_back(mem_addr);
                        log_wdata.push_back(mem_wdata);
                        mem_ready = 1'b1;
                        mem_cnt   = 0;
                    end else begin
                        mem_cnt++;
                    end
                end else begin
                    mem_cnt = 0;
                end
            end
        end
    end

    // One access held until dhit; loads push expected data, popped on completion.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic be, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rd,
                             input int exp_stall);
        int          stall;
        bit          done;
        logic [31:0] e;
        rd_en = rd; wr_en = wr; byte_en = be; addr = a; wdata = wd;
        if (rd && !wr) q_exp.push_back(exp_rd);
        #1;
        stall = 0;
        done  = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (dhit) begin
                done = 1'b1;
                if (rd && !wr) begin
                    e = q_exp.pop_front();
                    check({tag, "_rdata"}, 128'(rdata), 128'(e));
                end
            end else begin
                stall++;
            end
            @(posedge clk);
            #3;
        end
        if (!done) check({tag, "_timeout"}, 128'(0), 128'(1));
        check({tag, "_stall"}, 128'(stall), 128'(exp_stall));
        rd_en = 1'b0; wr_en = 1'b0; byte_en = 1'b0;
    endtask

    task automatic chk_log(input string tag, input logic we, input logic [27:0] a);
        if (log_addr.size() == 0) begin
            check({tag, "_present"}, 128'(0), 128'(1));
        end else begin
            check({tag, "_we"},   128'(log_we.pop_front()),   128'(we));
            check({tag, "_addr"}, 128'(log_addr.pop_front()), 128'(a));
            last_wdata = log_wdata.pop_front();
        end
    endtask

    task automatic clr_log();
        log_we.delete(); log_addr.delete(); log_wdata.delete();
    endtask

    initial begin
        bit seen;
        mem[28'h004] = 128'h11111111_22222222_33333333_44444444;
        mem[28'h008] = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
        mem[28'h009] = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; byte_en = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_mem_req", 128'(mem_req), 128'(0));
        check("rst_mem_we",  128'(mem_we),  128'(0));
        check("rst_dhit",    128'(dhit),    128'(1));
`ifdef DCACHE_PERF_EN
        check("rst_hit_count",  128'(hit_count),  128'(0));
        check("rst_miss_count", 128'(miss_count), 128'(0));
`endif

        // Clean miss on 0x40, then reload of word 3.
        do_access("ld40_miss", 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 32'h11111111, 3);
        check("ld40_nlog", 128'(log_addr.size()), 128'(1));
        chk_log("ld40_refill", 1'b0, 28'h0000004);
        do_access("ld4c_hit", 1'b1, 1'b0, 1'b0, 32'h4C, 32'd0, 32'h44444444, 0);
`ifdef DCACHE_PERF_EN
        check("perf_miss", 128'(miss_count), 128'(1));
        check("perf_hit",  128'(hit_count),  128'(2));
`endif

        // Byte store hit to lane 1, read back.
        do_access("sb41", 1'b0, 1'b1, 1'b1, 32'h41, 32'h000000AB, 32'd0, 0);
        do_access("ld40_merged", 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 32'h11AB1111, 0);
        check("sb41_nolog", 128'(log_addr.size()), 128'(0));

        // Dirty conflict miss: write-back of line 0x004, refill of 0x008.
        do_access("ld80_dirty", 1'b1, 1'b0, 1'b0, 32'h80, 32'd0, 32'hA0A0A0A0, 5);
        check("ld80_nlog", 128'(log_addr.size()), 128'(2));
        chk_log("ld80_wb", 1'b1, 28'h0000004);
        check("ld80_wb_word0", 128'(last_wdata[127:96]), 128'(32'h11AB1111));
        chk_log("ld80_refill", 1'b0, 28'h0000008);
        check("ld80_mem_line", rd_line(28'h004), 128'h11AB1111_22222222_33333333_44444444);

        // Word store miss to clean line 0x94: refill then replayed store.
        do_access("sw94_miss", 1'b0, 1'b1, 1'b0, 32'h94, 32'hDEADBEEF, 32'd0, 3);
        check("sw94_nlog", 128'(log_addr.size()), 128'(1));
        chk_log("sw94_refill", 1'b0, 28'h0000009);
        do_access("ld94_hit", 1'b1, 1'b0, 1'b0, 32'h94, 32'd0, 32'hDEADBEEF, 0);
        do_access("ld98_hit", 1'b1, 1'b0, 1'b0, 32'h98, 32'd0, 32'hB2B2B2B2, 0);

        // Reset while the refill handshake completes.
        clr_log();
        rd_en = 1'b1; wr_en = 1'b0; addr = 32'hC0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #3;
            if (mem_ready) seen = 1'b1;
        end
        check("rst_wait_ready", 128'(seen), 128'(1));
        reset = 1'b1; rd_en = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_refill_mem_req", 128'(mem_req), 128'(0));
        check("rst_refill_dhit",    128'(dhit),    128'(1));
        clr_log();
        do_access("ldc0_remiss", 1'b1, 1'b0, 1'b0, 32'hC0, 32'd0, 32'h0000000C, 3);
        do_access("ld94_lost",   1'b1, 1'b0, 1'b0, 32'h94, 32'd0, 32'hB1B1B1B1, 3);
        clr_log();

        // Zero-wait memory: ready in the first request cycle.
        mem_lat = 0;
        do_access("ld1a0_zw", 1'b1, 1'b0, 1'b0, 32'h1A0, 32'd0, 32'h0000001A, 2);
        chk_log("ld1a0_refill", 1'b0, 28'h000001A);
        do_access("ld1a4_hit", 1'b1, 1'b0, 1'b0, 32'h1A4, 32'd0, 32'h0000001A, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
